color_cmd_writer: RTL and testbench

//  Initiator side of the colour-register write handshake (address/data/valid -> ack).

---
 rtl/color_cmd_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_color_cmd_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_cmd_writer.sv
// color_cmd_writer
//   Initiator side of the colour-register write handshake. Parses framed
//   command bytes from uart_rx, queues {last,channel,address,data} entries in
//   a small FIFO and issues them one at a time to the colour register file.
//
//   Frame: header {4'hC,2'b00,ch[1:0]}, count byte N (1..MAX_WRITES), then N
//   payload bytes {addr[3:0],data[3:0]}.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rx_data/rx_valid    received byte and its 1-cycle strobe
//   rx_ready            parser can take a byte (low only in PAYLOAD with FIFO full)
//   channel/address/data  current write, stable while valid=1, held afterwards
//   valid/ack           write request level / write accepted level
//   frame_done          pulse: last write of a frame acked or timed out
//   err_hdr             pulse: bad header or bad count byte
//   err_timeout         pulse: write aborted after ACK_TIMEOUT cycles
//   o_dbg_parser_state  parser FSM state (0 IDLE, 1 COUNT, 2 PAYLOAD)
//   o_dbg_issuer_state  issuer FSM state (0 READY, 1 WAIT)
//
// Handshakes
//   Byte input: a byte is taken on a rising edge where rx_valid & rx_ready.
//   A strobe while rx_ready is low is dropped (uart_rx cannot stall).
//   Write output: 4-phase. valid rises with channel/address/data stable; it
//   stays high until ack is seen (or the timeout fires), then falls for at
//   least one cycle. A new write starts only once ack has returned low.
module color_cmd_writer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_WRITES  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [1:0] channel,
  output logic [3:0] address,
  output logic [3:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_done,
  output logic       err_hdr,
  output logic       err_timeout,
  output logic [1:0] o_dbg_parser_state,
  output logic       o_dbg_issuer_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_COUNT   = 2'd1,
    P_PAYLOAD = 2'd2
  } parser_state_t;

  typedef enum logic {
    I_READY = 1'b0,
    I_WAIT  = 1'b1
  } issuer_state_t;

  // Parser
  parser_state_t r_pstate, w_pstate_nxt;
  logic [1:0]    r_ch_pending, w_ch_pending_nxt;
  logic [7:0]    r_remaining, w_remaining_nxt;
  logic          r_err_hdr, w_err_hdr_nxt;
  logic          w_accept;
  logic          w_push;
  logic [10:0]   w_push_entry;

  // FIFO
  logic [10:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_empty, w_pop;
  logic [10:0]   w_head;

  // Issuer
  issuer_state_t r_istate, w_istate_nxt;
  logic          r_valid, w_valid_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_last;
  logic [1:0]    r_channel;
  logic [3:0]    r_address, r_data;
  logic          r_frame_done, w_frame_done_nxt;
  logic          r_err_timeout, w_err_timeout_nxt;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign rx_ready = !((r_pstate == P_PAYLOAD) && w_full);
  assign w_accept = rx_valid && rx_ready;

  // Parser next-state
  always_comb begin
    w_pstate_nxt     = r_pstate;
    w_ch_pending_nxt = r_ch_pending;
    w_remaining_nxt  = r_remaining;
    w_err_hdr_nxt    = 1'b0;
    w_push           = 1'b0;
    w_push_entry     = '0;
    if (w_accept) begin
      case (r_pstate)
        P_IDLE: begin
          if ((rx_data[7:4] == 4'hC) && (rx_data[3:2] == 2'b00)) begin
            w_ch_pending_nxt = rx_data[1:0];
            w_pstate_nxt     = P_COUNT;
          end else begin
            w_err_hdr_nxt = 1'b1;
          end
        end
        P_COUNT: begin
          if ((rx_data >= 8'd1) && (rx_data <= 8'(MAX_WRITES))) begin
            w_remaining_nxt = rx_data;
            w_pstate_nxt    = P_PAYLOAD;
          end else begin
            w_err_hdr_nxt = 1'b1;
            w_pstate_nxt  = P_IDLE;
          end
        end
        P_PAYLOAD: begin
          w_push          = 1'b1;
          w_push_entry    = {(r_remaining == 8'd1), r_ch_pending, rx_data};
          w_remaining_nxt = r_remaining - 8'd1;
          if (r_remaining == 8'd1) begin
            w_pstate_nxt = P_IDLE;
          end
        end
        default: w_pstate_nxt = P_IDLE;
      endcase
    end
  end

  // Issuer next-state; decisions use the FIFO contents before this edge's push
  always_comb begin
    w_istate_nxt      = r_istate;
    w_pop             = 1'b0;
    w_valid_nxt       = r_valid;
    w_timer_nxt       = r_timer;
    w_frame_done_nxt  = 1'b0;
    w_err_timeout_nxt = 1'b0;
    case (r_istate)
      I_READY: begin
        if (!w_empty && !ack) begin
          w_pop        = 1'b1;
          w_valid_nxt  = 1'b1;
          w_timer_nxt  = '0;
          w_istate_nxt = I_WAIT;
        end
      end
      I_WAIT: begin
        // ack is tested first so it wins over a coincident timeout
        if (ack) begin
          w_valid_nxt      = 1'b0;
          w_frame_done_nxt = r_last;
          w_istate_nxt     = I_READY;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
          w_valid_nxt       = 1'b0;
          w_err_timeout_nxt = 1'b1;
          w_frame_done_nxt  = r_last;
          w_istate_nxt      = I_READY;
        end else if (r_timer != '1) begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_istate_nxt = I_READY;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pstate      <= P_IDLE;
      r_ch_pending  <= '0;
      r_remaining   <= '0;
      r_err_hdr     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_istate      <= I_READY;
      r_valid       <= 1'b0;
      r_timer       <= '0;
      r_last        <= 1'b0;
      r_channel     <= '0;
      r_address     <= '0;
      r_data        <= '0;
      r_frame_done  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_pstate      <= w_pstate_nxt;
      r_ch_pending  <= w_ch_pending_nxt;
      r_remaining   <= w_remaining_nxt;
      r_err_hdr     <= w_err_hdr_nxt;
      r_istate      <= w_istate_nxt;
      r_valid       <= w_valid_nxt;
      r_timer       <= w_timer_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_last    <= w_head[10];
        r_channel <= w_head[9:8];
        r_address <= w_head[7:4];
        r_data    <= w_head[3:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers and count define its contents
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  assign channel            = r_channel;
  assign address            = r_address;
  assign data               = r_data;
  assign valid              = r_valid;
  assign frame_done         = r_frame_done;
  assign err_hdr            = r_err_hdr;
  assign err_timeout        = r_err_timeout;
  assign o_dbg_parser_state = r_pstate;
  assign o_dbg_issuer_state = r_istate;

endmodule

// File: tb/tb_color_cmd_writer.sv
// tb_color_cmd_writer
//   Directed bench for color_cmd_writer. A queue-based model of the frame
//   rules predicts every output each cycle; directed tests add hand-computed
//   literal expectations for the writes issued, pulse counts and durations.
module tb_color_cmd_writer;

  localparam int FIFO_DEPTH  = 4;
  localparam int MAX_WRITES  = 8;
  localparam int ACK_TIMEOUT = 255;

  // ---------------- clock / reset / DUT ----------------
  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ack      = 1'b0;
  logic       rx_ready;
  logic [1:0] channel;
  logic [3:0] address;
  logic [3:0] data;
  logic       valid;
  logic       frame_done;
  logic       err_hdr;
  logic       err_timeout;
  logic [1:0] dbg_pstate;
  logic       dbg_istate;

  always #5 clk = ~clk;

  color_cmd_writer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_WRITES (MAX_WRITES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .channel           (channel),
    .address           (address),
    .data              (data),
    .valid             (valid),
    .ack               (ack),
    .frame_done        (frame_done),
    .err_hdr           (err_hdr),
    .err_timeout       (err_timeout),
    .o_dbg_parser_state(dbg_pstate),
    .o_dbg_issuer_state(dbg_istate)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- ack responder ----------------
  // Raises ack on the ack_delay-th falling edge that sees valid, holds it
  // until valid drops.
  bit ack_en    = 1'b1;
  int ack_delay = 1;
  int ack_cnt   = 0;

  always @(negedge clk) begin
    if (!valid) begin
      ack     = 1'b0;
      ack_cnt = 0;
    end else if (ack_en && !ack) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) ack = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [10:0] exp_q[$];          // accepted writes not yet issued {last,ch,addr,data}
  int          m_pstate = 0;      // 0 header, 1 count, 2 payload
  logic [1:0]  m_chp    = '0;
  int          m_rem    = 0;
  bit          m_busy   = 1'b0;
  int          m_wait   = 0;
  logic [10:0] m_cur    = '0;
  logic [1:0]  m_ch     = '0;
  logic [3:0]  m_addr   = '0;
  logic [3:0]  m_data   = '0;
  bit          m_fd = 1'b0, m_eh = 1'b0, m_to = 1'b0;
  bit          m_rx_ready = 1'b1;
  bit          m_acc;

  // Observed statistics used by the directed literal checks
  logic [9:0]  issued_q[$];
  int          runs_q[$];
  int          run = 0;
  bit          prev_valid = 1'b0;
  int          fd_cnt = 0, eh_cnt = 0, to_cnt = 0, rdy_low_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_pstate = 0; m_chp = '0; m_rem = 0;
      m_busy = 1'b0; m_wait = 0; m_cur = '0;
      m_ch = '0; m_addr = '0; m_data = '0;
      m_fd = 1'b0; m_eh = 1'b0; m_to = 1'b0;
      m_rx_ready = 1'b1;
    end else begin
      m_acc = rx_valid && m_rx_ready;
      m_fd = 1'b0; m_eh = 1'b0; m_to = 1'b0;
      if (m_busy) begin
        if (ack) begin
          m_busy = 1'b0;
          m_fd   = m_cur[10];
        end else if (m_wait == ACK_TIMEOUT - 1) begin
          m_busy = 1'b0;
          m_to   = 1'b1;
          m_fd   = m_cur[10];
        end else begin
          m_wait++;
        end
      end else if (exp_q.size() > 0 && !ack) begin
        m_cur  = exp_q.pop_front();
        m_busy = 1'b1;
        m_wait = 0;
        {m_ch, m_addr, m_data} = m_cur[9:0];
      end
      if (m_acc) begin
        if (m_pstate == 0) begin
          if (rx_data[7:4] == 4'hC && rx_data[3:2] == 2'b00) begin
            m_chp = rx_data[1:0];
            m_pstate = 1;
          end else begin
            m_eh = 1'b1;
          end
        end else if (m_pstate == 1) begin
          if (rx_data >= 1 && rx_data <= MAX_WRITES) begin
            m_rem = int'(rx_data);
            m_pstate = 2;
          end else begin
            m_eh = 1'b1;
            m_pstate = 0;
          end
        end else begin
          exp_q.push_back({m_rem == 1, m_chp, rx_data});
          m_rem--;
          if (m_rem == 0) m_pstate = 0;
        end
      end
      m_rx_ready = !(m_pstate == 2 && exp_q.size() == FIFO_DEPTH);
    end

    check("valid",       valid,       m_busy);
    check("rx_ready",    rx_ready,    m_rx_ready);
    check("channel",     channel,     m_ch);
    check("address",     address,     m_addr);
    check("data",        data,        m_data);
    check("frame_done",  frame_done,  m_fd);
    check("err_hdr",     err_hdr,     m_eh);
    check("err_timeout", err_timeout, m_to);

    if (valid) begin
      if (!prev_valid) begin
        run = 1;
        issued_q.push_back({channel, address, data});
      end else begin
        run++;
      end
    end else if (prev_valid) begin
      runs_q.push_back(run);
    end
    prev_valid = valid;
    if (frame_done)  fd_cnt++;
    if (err_hdr)     eh_cnt++;
    if (err_timeout) to_cnt++;
    if (!rx_ready)   rdy_low_cnt++;
  end

  function automatic logic [9:0] get_iss(input int idx);
    if (idx < issued_q.size()) return issued_q[idx];
    return 10'h3FF;
  endfunction

  function automatic int get_run(input int idx);
    if (idx < runs_q.size()) return runs_q[idx];
    return -1;
  endfunction

  // ---------------- directed tests ----------------
  int b_iss, b_fd, b_eh, b_to, b_run, b_rdy;
  bit found;

  task automatic snap();
    b_iss = issued_q.size();
    b_fd  = fd_cnt;
    b_eh  = eh_cnt;
    b_to  = to_cnt;
    b_run = runs_q.size();
    b_rdy = rdy_low_cnt;
  endtask

  initial begin
    // reset
    idle(4);
    check("rst_valid",       valid,       1'b0);
    check("rst_rx_ready",    rx_ready,    1'b1);
    check("rst_frame_done",  frame_done,  1'b0);
    check("rst_err_hdr",     err_hdr,     1'b0);
    check("rst_err_timeout", err_timeout, 1'b0);
    check("rst_addr_data",   {channel, address, data}, 10'h000);
    check("rst_states",      {dbg_pstate, dbg_istate}, 3'b000);
    rst = 1'b0;
    idle(2);

    // T1: two writes on channel 2, ack one cycle after valid
    snap();
    drive_byte(8'hC2); drive_byte(8'h02); drive_byte(8'h35); drive_byte(8'h4A);
    idle(20);
    check("t1_writes",     issued_q.size() - b_iss, 2);
    check("t1_wr0",        get_iss(b_iss),     10'h235);
    check("t1_wr1",        get_iss(b_iss + 1), 10'h24A);
    check("t1_frame_done", fd_cnt - b_fd, 1);

    // T2: bad header then a good frame on channel 1
    snap();
    drive_byte(8'h55); idle(2);
    drive_byte(8'hC1); drive_byte(8'h01); drive_byte(8'h7E);
    idle(10);
    check("t2_err_hdr",    eh_cnt - b_eh, 1);
    check("t2_writes",     issued_q.size() - b_iss, 1);
    check("t2_wr0",        get_iss(b_iss), 10'h17E);
    check("t2_frame_done", fd_cnt - b_fd, 1);

    // T3: count 00, count 09, header with reserved bits set
    snap();
    drive_byte(8'hC0); drive_byte(8'h00); idle(2);
    drive_byte(8'hC0); drive_byte(8'h09); idle(2);
    drive_byte(8'hC4); idle(5);
    check("t3_err_hdr",     eh_cnt - b_eh, 3);
    check("t3_no_writes",   issued_q.size() - b_iss, 0);
    check("t3_parser_idle", dbg_pstate, 2'd0);

    // T4: no ack at all -> both writes time out after exactly 255 cycles
    ack_en = 1'b0;
    snap();
    drive_byte(8'hC3); drive_byte(8'h02); drive_byte(8'h12); drive_byte(8'h34);
    idle(600);
    check("t4_timeouts",   to_cnt - b_to, 2);
    check("t4_frame_done", fd_cnt - b_fd, 1);
    check("t4_writes",     issued_q.size() - b_iss, 2);
    check("t4_wr0",        get_iss(b_iss),     10'h312);
    check("t4_wr1",        get_iss(b_iss + 1), 10'h334);
    check("t4_run0",       get_run(b_run),     255);
    check("t4_run1",       get_run(b_run + 1), 255);

    // T4b: ack lands on the timeout cycle -> ack wins
    ack_en = 1'b1;
    ack_delay = 255;
    snap();
    drive_byte(8'hC2); drive_byte(8'h01); drive_byte(8'h9C);
    idle(300);
    check("t4b_no_timeout", to_cnt - b_to, 0);
    check("t4b_frame_done", fd_cnt - b_fd, 1);
    check("t4b_wr0",        get_iss(b_iss), 10'h29C);
    check("t4b_run0",       get_run(b_run), 255);

    // T5: full-length frame back-to-back, slow ack -> FIFO fills, p5..p7 lost
    ack_delay = 10;
    snap();
    drive_byte(8'hC0); drive_byte(8'h08);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] a;
      a = 4'(i);
      drive_byte({a, ~a});
    end
    idle(150);
    check("t5_writes", issued_q.size() - b_iss, 5);
    for (int j = 0; j < 5; j++) begin
      logic [3:0] a;
      a = 4'(j);
      check($sformatf("t5_wr%0d", j), get_iss(b_iss + j), {2'd0, a, ~a});
    end
    check("t5_rx_ready_low", (rdy_low_cnt - b_rdy) > 0, 1'b1);
    check("t5_no_frame_done", fd_cnt - b_fd, 0);
    check("t5_parser_payload", dbg_pstate, 2'd2);

    // T6: finish the frame with a very slow ack, reset while valid=1
    ack_delay = 50;
    snap();
    drive_byte(8'h5A); idle(1);
    drive_byte(8'h69); idle(1);
    drive_byte(8'h78);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (valid) found = 1'b1;
    end
    check("t6_valid_seen", found, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid_dropped", valid,    1'b0);
    check("t6_rx_ready",      rx_ready, 1'b1);
    rst = 1'b0;
    idle(5);
    check("t6_no_frame_done", fd_cnt - b_fd, 0);
    check("t6_no_err",        (eh_cnt - b_eh) + (to_cnt - b_to), 0);
    ack_delay = 1;
    snap();
    drive_byte(8'hC1); drive_byte(8'h01); drive_byte(8'h5A);
    idle(12);
    check("t6_flushed_writes", issued_q.size() - b_iss, 1);
    check("t6_wr0",            get_iss(b_iss), 10'h15A);
    check("t6_frame_done",     fd_cnt - b_fd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
